// File: rtl/blackjack_multi_ctrl.sv
// Multi-seat blackjack sequencer: shuffle, round-robin deal, player turns, dealer auto-play, latched results.
// Optional idle auto-stay per seat is compiled in with `define PLAYER_TIMEOUT_EN.
module blackjack_multi_ctrl #(
    parameter int N_PLAYERS      = 2,
    parameter int DISPLAY_CYCLES = 100000000,
    parameter int DEALER_STAND   = 17,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_new_game,
    input  logic                   i_shuffle_ok,
    input  logic                   i_card_ok,
    input  logic [N_PLAYERS-1:0]   i_hit,
    input  logic [N_PLAYERS-1:0]   i_stay,
    input  logic [6*N_PLAYERS-1:0] i_pts_players,
    input  logic [5:0]             i_pts_dealer,
    output logic                   o_shuffle_start,
    output logic                   o_req_valid,
    output logic                   o_req_dealer,
    output logic [2:0]             o_req_seat,
    output logic [2:0]             o_active_seat,
    output logic                   o_player_hit,
    output logic                   o_player_stay,
    output logic                   o_dealer_hit,
    output logic                   o_dealer_stay,
    output logic [N_PLAYERS-1:0]   o_win,
    output logic [N_PLAYERS-1:0]   o_lose,
    output logic [N_PLAYERS-1:0]   o_tie,
    output logic                   o_game_done
);

    localparam int                DISP_W        = $clog2(DISPLAY_CYCLES);
    localparam logic [DISP_W-1:0] DISP_LAST     = DISP_W'(DISPLAY_CYCLES - 1);
    localparam logic [5:0]        STAND_PTS     = 6'(DEALER_STAND);
    localparam logic [2:0]        LAST_SEAT     = 3'(N_PLAYERS - 1);
    localparam logic [3:0]        DEAL_LAST_POS = 4'(N_PLAYERS);

    typedef enum logic [3:0] {
        S_IDLE, S_SHUFFLE, S_DEAL, S_DEAL_WAIT,
        S_PLAYER_TURN, S_P_HIT_SHOW, S_P_FETCH, S_P_WAIT, S_P_STAY_SHOW, S_NEXT_SEAT,
        S_DEALER_TURN, S_D_HIT_SHOW, S_D_FETCH, S_D_WAIT, S_D_STAY_SHOW, S_RESULT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_seat;
    logic [2:0]          w_seat_next;
    logic [3:0]          r_deal_pos;
    logic [3:0]          w_deal_pos_next;
    logic                r_deal_round;
    logic                w_deal_round_next;
    logic [DISP_W-1:0]   r_disp_cnt;
    logic                w_disp_done;
    logic                w_timeout;

    logic [5:0]          w_pts [N_PLAYERS];
    logic [N_PLAYERS-1:0] w_bust;
    logic [N_PLAYERS-1:0] w_res_win;
    logic [N_PLAYERS-1:0] w_res_lose;
    logic [N_PLAYERS-1:0] w_res_tie;
    logic                w_dealer_bust;
    logic                w_all_bust;
    logic [5:0]          w_cur_pts;
    logic                w_cur_hit;
    logic                w_cur_stay;

    logic                w_shuffle_start;
    logic                w_req_valid;
    logic                w_req_dealer;
    logic [2:0]          w_req_seat;
    logic                w_player_hit;
    logic                w_player_stay;
    logic                w_dealer_hit;
    logic                w_dealer_stay;
    logic                w_game_done;

    assign w_dealer_bust = i_pts_dealer > 6'd21;
    assign w_all_bust    = &w_bust;

    // Per-seat score slicing and outcome evaluation against the dealer
    generate
        for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_seat
            assign w_pts[gi]      = i_pts_players[6*gi +: 6];
            assign w_bust[gi]     = w_pts[gi] > 6'd21;
            assign w_res_lose[gi] = w_bust[gi] | (!w_dealer_bust & (w_pts[gi] < i_pts_dealer));
            assign w_res_win[gi]  = !w_bust[gi] & (w_dealer_bust | (w_pts[gi] > i_pts_dealer));
            assign w_res_tie[gi]  = !w_bust[gi] & !w_dealer_bust & (w_pts[gi] == i_pts_dealer);
        end
    endgenerate

    always_comb begin
        w_cur_pts  = 6'd0;
        w_cur_hit  = 1'b0;
        w_cur_stay = 1'b0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (r_seat == 3'(i)) begin
                w_cur_pts  = w_pts[i];
                w_cur_hit  = i_hit[i];
                w_cur_stay = i_stay[i];
            end
        end
    end

    assign w_disp_done = (r_disp_cnt == DISP_LAST);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_disp_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_disp_cnt <= '0;
        end else begin
            r_disp_cnt <= r_disp_cnt + DISP_W'(1);
        end
    end

`ifdef PLAYER_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] r_idle_cnt;

    assign w_timeout = (r_idle_cnt == TO_LAST);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_idle_cnt <= '0;
        end else if ((r_state != S_PLAYER_TURN) || (w_state_next != S_PLAYER_TURN)) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + TO_W'(1);
        end
    end
`else
    // Auto-stay compiled out; the parameter stays referenced so the interface is identical.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_seat       <= 3'd0;
            r_deal_pos   <= 4'd0;
            r_deal_round <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_seat       <= w_seat_next;
            r_deal_pos   <= w_deal_pos_next;
            r_deal_round <= w_deal_round_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_seat_next       = r_seat;
        w_deal_pos_next   = r_deal_pos;
        w_deal_round_next = r_deal_round;
        case (r_state)
            S_IDLE: w_state_next = S_SHUFFLE;
            S_SHUFFLE: begin
                w_seat_next       = 3'd0;
                w_deal_pos_next   = 4'd0;
                w_deal_round_next = 1'b0;
                if (i_shuffle_ok) w_state_next = S_DEAL;
            end
            S_DEAL: if (i_card_ok) w_state_next = S_DEAL_WAIT;
            S_DEAL_WAIT: begin
                if (!i_card_ok) begin
                    // Position N_PLAYERS is the dealer's slot; two passes make the opening hand
                    if (r_deal_pos == DEAL_LAST_POS) begin
                        if (r_deal_round) begin
                            w_seat_next  = 3'd0;
                            w_state_next = S_PLAYER_TURN;
                        end else begin
                            w_deal_pos_next   = 4'd0;
                            w_deal_round_next = 1'b1;
                            w_state_next      = S_DEAL;
                        end
                    end else begin
                        w_deal_pos_next = r_deal_pos + 4'd1;
                        w_state_next    = S_DEAL;
                    end
                end
            end
            S_PLAYER_TURN: begin
                if (w_cur_pts >= 6'd21)        w_state_next = S_NEXT_SEAT;
                else if (w_cur_hit)            w_state_next = S_P_HIT_SHOW;
                else if (w_cur_stay || w_timeout) w_state_next = S_P_STAY_SHOW;
            end
            S_P_HIT_SHOW:  if (w_disp_done) w_state_next = S_P_FETCH;
            S_P_FETCH:     if (i_card_ok)   w_state_next = S_P_WAIT;
            S_P_WAIT:      if (!i_card_ok)  w_state_next = S_PLAYER_TURN;
            S_P_STAY_SHOW: if (w_disp_done) w_state_next = S_NEXT_SEAT;
            S_NEXT_SEAT: begin
                if (r_seat < LAST_SEAT) begin
                    w_seat_next  = r_seat + 3'd1;
                    w_state_next = S_PLAYER_TURN;
                end else if (w_all_bust) begin
                    w_state_next = S_RESULT;
                end else begin
                    w_state_next = S_DEALER_TURN;
                end
            end
            S_DEALER_TURN: begin
                if (w_dealer_bust)                  w_state_next = S_RESULT;
                else if (i_pts_dealer >= STAND_PTS) w_state_next = S_D_STAY_SHOW;
                else                                w_state_next = S_D_HIT_SHOW;
            end
            S_D_HIT_SHOW:  if (w_disp_done) w_state_next = S_D_FETCH;
            S_D_FETCH:     if (i_card_ok)   w_state_next = S_D_WAIT;
            S_D_WAIT:      if (!i_card_ok)  w_state_next = S_DEALER_TURN;
            S_D_STAY_SHOW: if (w_disp_done) w_state_next = S_RESULT;
            S_RESULT:      if (i_new_game)  w_state_next = S_SHUFFLE;
            default:       w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with r_state
    always_comb begin
        w_shuffle_start = 1'b0;
        w_req_valid     = 1'b0;
        w_req_dealer    = 1'b0;
        w_req_seat      = 3'd0;
        w_player_hit    = 1'b0;
        w_player_stay   = 1'b0;
        w_dealer_hit    = 1'b0;
        w_dealer_stay   = 1'b0;
        w_game_done     = 1'b0;
        case (w_state_next)
            S_SHUFFLE: w_shuffle_start = 1'b1;
            S_DEAL: begin
                w_req_valid = 1'b1;
                if (w_deal_pos_next == DEAL_LAST_POS) w_req_dealer = 1'b1;
                else                                  w_req_seat   = w_deal_pos_next[2:0];
            end
            S_P_FETCH: begin
                w_req_valid = 1'b1;
                w_req_seat  = w_seat_next;
            end
            S_D_FETCH: begin
                w_req_valid  = 1'b1;
                w_req_dealer = 1'b1;
            end
            S_P_HIT_SHOW:  w_player_hit  = 1'b1;
            S_P_STAY_SHOW: w_player_stay = 1'b1;
            S_D_HIT_SHOW:  w_dealer_hit  = 1'b1;
            S_D_STAY_SHOW: w_dealer_stay = 1'b1;
            S_RESULT:      w_game_done   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_shuffle_start <= 1'b0;
            o_req_valid     <= 1'b0;
            o_req_dealer    <= 1'b0;
            o_req_seat      <= 3'd0;
            o_player_hit    <= 1'b0;
            o_player_stay   <= 1'b0;
            o_dealer_hit    <= 1'b0;
            o_dealer_stay   <= 1'b0;
            o_game_done     <= 1'b0;
        end else begin
            o_shuffle_start <= w_shuffle_start;
            o_req_valid     <= w_req_valid;
            o_req_dealer    <= w_req_dealer;
            o_req_seat      <= w_req_seat;
            o_player_hit    <= w_player_hit;
            o_player_stay   <= w_player_stay;
            o_dealer_hit    <= w_dealer_hit;
            o_dealer_stay   <= w_dealer_stay;
            o_game_done     <= w_game_done;
        end
    end

    // Outcomes are captured once on entry to RESULT and held until the next hand starts
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_win  <= '0;
            o_lose <= '0;
            o_tie  <= '0;
        end else if ((w_state_next == S_RESULT) && (r_state != S_RESULT)) begin
            o_win  <= w_res_win;
            o_lose <= w_res_lose;
            o_tie  <= w_res_tie;
        end else if ((r_state == S_RESULT) && (w_state_next != S_RESULT)) begin
            o_win  <= '0;
            o_lose <= '0;
            o_tie  <= '0;
        end
    end

    assign o_active_seat = r_seat;

endmodule

// File: tb/tb_blackjack_multi_ctrl.sv
// Directed bench for blackjack_multi_ctrl with scoreboards for card requests and hand results.
module tb_blackjack_multi_ctrl;

    localparam int N  = 2;
    localparam int DC = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           new_game = 1'b0;
    logic           shuffle_ok = 1'b0;
    logic           card_ok = 1'b0;
    logic [N-1:0]   hit = '0;
    logic [N-1:0]   stay = '0;
    logic [6*N-1:0] pts_players = '0;
    logic [5:0]     pts_dealer = '0;

    logic           shuffle_start, req_valid, req_dealer, game_done;
    logic [2:0]     req_seat, active_seat;
    logic           player_hit, player_stay, dealer_hit, dealer_stay;
    logic [N-1:0]   win, lose, tie;
    logic [19:0]    all_out;

    int   checks = 0;
    int   errors = 0;
    logic ack_en = 1'b1;
    logic [3:0]     req_q[$];
    logic [3*N-1:0] res_q[$];

    blackjack_multi_ctrl #(
        .N_PLAYERS(N), .DISPLAY_CYCLES(DC), .DEALER_STAND(17), .TIMEOUT_CYCLES(1000)
    ) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_new_game(new_game), .i_shuffle_ok(shuffle_ok),
        .i_card_ok(card_ok), .i_hit(hit), .i_stay(stay), .i_pts_players(pts_players),
        .i_pts_dealer(pts_dealer), .o_shuffle_start(shuffle_start), .o_req_valid(req_valid),
        .o_req_dealer(req_dealer), .o_req_seat(req_seat), .o_active_seat(active_seat),
        .o_player_hit(player_hit), .o_player_stay(player_stay), .o_dealer_hit(dealer_hit),
        .o_dealer_stay(dealer_stay), .o_win(win), .o_lose(lose), .o_tie(tie),
        .o_game_done(game_done)
    );

    assign all_out = {shuffle_start, req_valid, req_dealer, req_seat, active_seat, player_hit,
                      player_stay, dealer_hit, dealer_stay, win, lose, tie, game_done};

    always #5 clk = ~clk;

    // Deck model: acknowledgement follows the request one cycle later
    initial begin
        forever begin
            @(posedge clk);
            #1;
            card_ok = ack_en ? req_valid : 1'b0;
        end
    end

    initial begin
        logic       prev = 1'b0;
        logic [3:0] exp_r;
        forever begin
            @(negedge clk);
            if (req_valid && !prev) begin
                checks++;
                assert (req_q.size() != 0) else begin
                    errors++;
                    $error("FAIL req_unexpected obs dealer=%0d seat=%0d exp none", req_dealer, req_seat);
                end
                if (req_q.size() != 0) begin
                    exp_r = req_q.pop_front();
                    checks++;
                    assert ({req_dealer, req_seat} === exp_r) else begin
                        errors++;
                        $error("FAIL req_target obs=%h exp=%h", {req_dealer, req_seat}, exp_r);
                    end
                end
                $display("req dealer=%0d seat=%0d", req_dealer, req_seat);
            end
            prev = req_valid;
        end
    end

    initial begin
        logic           prev = 1'b0;
        logic [3*N-1:0] exp_r;
        forever begin
            @(negedge clk);
            if (game_done && !prev) begin
                checks++;
                assert (res_q.size() != 0) else begin
                    errors++;
                    $error("FAIL res_unexpected obs=%b exp none", {win, lose, tie});
                end
                if (res_q.size() != 0) begin
                    exp_r = res_q.pop_front();
                    checks++;
                    assert ({win, lose, tie} === exp_r) else begin
                        errors++;
                        $error("FAIL result obs win/lose/tie=%b exp=%b", {win, lose, tie}, exp_r);
                    end
                end
                $display("result win=%b lose=%b tie=%b", win, lose, tie);
            end
            prev = game_done;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return shuffle_start;
            1: return req_valid;
            2: return player_hit;
            3: return player_stay;
            4: return dealer_hit;
            5: return dealer_stay;
            6: return game_done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int w, input logic v, input int maxc, input string tag);
        int n = 0;
        while (sig(w) !== v && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sig(w)), 32'(v));
    endtask

    // Counts cycles with signal w high until signal stop_w rises
    task automatic count_until(input int w, input int stop_w, input int maxc, output int cnt);
        int n = 0;
        cnt = 0;
        while (!sig(stop_w) && n < maxc) begin
            if (sig(w)) cnt++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic push_deal();
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < N; s++) req_q.push_back({1'b0, 3'(s)});
            req_q.push_back(4'b1000);
        end
    endtask

    task automatic start_hand();
        shuffle_ok = 1'b1;
        @(negedge clk);
        shuffle_ok = 1'b0;
    endtask

    task automatic wait_deal(input string tag);
        int n = 0;
        while ((req_q.size() != 0 || req_valid || card_ok) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk(tag, 32'(req_q.size()), 32'd0);
    endtask

    initial begin
        int cnt;
        pts_players = {6'd15, 6'd15};
        pts_dealer  = 6'd10;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(all_out), 32'd0);

        // Hand 1: opening deal
        push_deal();
        rst_n = 1'b1;
        @(negedge clk);
        chk("shuffle_after_idle", 32'(shuffle_start), 32'd1);
        start_hand();
        wait_deal("deal1_done");
        chk("deal1_active_seat", 32'(active_seat), 32'd0);
        chk("deal1_req_idle", 32'(req_valid), 32'd0);

        // Player hit: 4-cycle indication then one seat-0 fetch
        req_q.push_back(4'b0000);
        hit = 2'b01;
        @(negedge clk);
        hit = 2'b00;
        count_until(2, 1, 50, cnt);
        chk("player_hit_len", 32'(cnt), 32'd4);
        wait_for(1, 1'b0, 20, "p_fetch_release");
        repeat (3) @(negedge clk);
        chk("after_hit_seat", 32'(active_seat), 32'd0);
        chk("after_hit_no_req", 32'(req_valid), 32'd0);
        chk("after_hit_q", 32'(req_q.size()), 32'd0);

        // All seats bust: dealer never draws
        res_q.push_back({2'b00, 2'b11, 2'b00});
        pts_players = {6'd23, 6'd25};
        count_until(4, 6, 100, cnt);
        chk("bust_no_dealer_hit", 32'(cnt), 32'd0);
        chk("bust_game_done", 32'(game_done), 32'd1);
        repeat (3) @(negedge clk);
        chk("bust_lose_hold", 32'(lose), 32'd3);

        // Hand 2: stay, stay, dealer draws once
        pts_players = {6'd18, 6'd20};
        pts_dealer  = 6'd16;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        chk("ng_shuffle", 32'(shuffle_start), 32'd1);
        chk("ng_done_clear", 32'(game_done), 32'd0);
        chk("ng_lose_clear", 32'(lose), 32'd0);
        push_deal();
        start_hand();
        wait_deal("deal2_done");
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        @(negedge clk);
        chk("ng_ignored_shuffle", 32'(shuffle_start), 32'd0);
        chk("ng_ignored_seat", 32'(active_seat), 32'd0);
        req_q.push_back(4'b1000);
        res_q.push_back({2'b01, 2'b10, 2'b00});
        stay = 2'b11;
        count_until(3, 4, 100, cnt);
        chk("player_stay_len", 32'(cnt), 32'd8);
        chk("dealer_hit_seen", 32'(dealer_hit), 32'd1);
        pts_dealer = 6'd19;
        stay = 2'b00;
        count_until(5, 6, 100, cnt);
        chk("dealer_stay_len", 32'(cnt), 32'd4);
        chk("hand2_done", 32'(game_done), 32'd1);
        chk("hand2_one_fetch", 32'(req_q.size()), 32'd0);

        // Hand 3: tie on seat 0, 21 on seat 1
        pts_players = {6'd21, 6'd19};
        pts_dealer  = 6'd19;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        push_deal();
        start_hand();
        wait_deal("deal3_done");
        res_q.push_back({2'b10, 2'b00, 2'b01});
        stay = 2'b01;
        wait_for(6, 1'b1, 200, "hand3_done");
        stay = 2'b00;
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        chk("h3_clear_win", 32'(win), 32'd0);
        chk("h3_clear_tie", 32'(tie), 32'd0);
        chk("h3_clear_done", 32'(game_done), 32'd0);
        chk("h3_shuffle", 32'(shuffle_start), 32'd1);

        // Hand 4: reset while a player fetch is outstanding
        pts_players = {6'd10, 6'd10};
        pts_dealer  = 6'd10;
        push_deal();
        start_hand();
        wait_deal("deal4_done");
        req_q.push_back(4'b0000);
        ack_en = 1'b0;
        hit = 2'b01;
        @(negedge clk);
        hit = 2'b00;
        wait_for(1, 1'b1, 50, "p_fetch_raise");
        repeat (3) @(negedge clk);
        chk("fetch_held", 32'(req_valid), 32'd1);
        chk("fetch_seat", 32'(req_seat), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(all_out), 32'd0);
        @(negedge clk);
        chk("reset_idle_outputs", 32'(all_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_shuffle", 32'(shuffle_start), 32'd1);
        chk("restart_req", 32'(req_valid), 32'd0);
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("res_q_empty", 32'(res_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
